wind_meas_scheduler: RTL and testbench
======================================

// Module: wind_meas_scheduler
// PURPOSE
//  Frame controller for the ultrasonic wind path. Steps round-robin through the four transducer paths
//  (0=N->S, 1=S->N, 2=E->W, 3=W->E) and fires the shared phase detector. Streams each phase result
//  into the shared phase-averaging/speed unit and collects one averaged speed per path.
//  Publishes per-axis differential speeds once per frame, with per-path fault flags.
// PARAMETERS
//  AVG_N     7     log2 of samples accumulated by averaging unit per path (must match its N)
//  SETTLE    255   idle cycles after a path switch before the first measurement (ring-down)
//  GAP       15    idle cycles between consecutive measurements on one path
//  TMO       4095  max cycles waiting for meas_done or avg_new before declaring path fault
// PORTS
//  clock       in   1   system clock
//  reset       in   1   synchronous, active-high
//  enable      in   1   run frames continuously while high
//  path_sel    out  2   transducer path currently driven (mux control)
//  meas_start  out  1   1-cycle pulse: phase detector fires burst on path_sel
//  meas_done   in   1   1-cycle pulse: meas_phase valid this cycle
//  meas_phase  in   19  signed phase from detector
//  avg_endata  out  1   1-cycle sample strobe to averaging unit
//  avg_phase   out  19  signed phase to averaging unit, registered, stable while avg_endata high
//  avg_reset   out  1   reset to averaging unit
//  avg_new     in   1   1-cycle pulse: avg_speed valid
//  avg_speed   in   16  signed averaged speed for current path
//  speed_ns    out  17  signed spd[0]-spd[1]
//  speed_ew    out  17  signed spd[2]-spd[3]
//  frame_valid out  1   1-cycle pulse: speed_ns/speed_ew/path_fault updated
//  path_fault  out  4   bit p set if path p timed out in the last reported frame
//  busy        out  1   high in every state except IDLE
// BEHAVIOUR
//  Reset: state IDLE, path_sel=0, all pulses 0, avg_phase=0, speed_ns=speed_ew=0, path_fault=0,
//   busy=0, spd[0..3]=0. avg_reset = reset OR internal clr pulse (combinational OR).
//  FSM: IDLE -> SETTLE -> START -> WAIT_MEAS -> FEED -> GAP -> (START | WAIT_AVG) -> STORE -> NEXT.
//  IDLE: enable=1 -> path_sel=0, clear fault accumulator, SETTLE. enable=0 -> stay.
//  SETTLE: count SETTLE cycles, then START.
//  START: meas_start=1 for exactly 1 cycle, load timeout counter, WAIT_MEAS.
//  WAIT_MEAS: meas_done -> register meas_phase into avg_phase, FEED.
//   Timeout reaching TMO without meas_done -> FAULT. meas_done in the expiry cycle wins (no fault).
//  FEED: avg_endata=1 for 1 cycle, increment sample count, GAP. Strobes are never back-to-back.
//  Sample count per path = (1<<AVG_N)+1: first strobe arms the averager, next 2^AVG_N accumulate.
//  GAP: count GAP cycles; count < (1<<AVG_N)+1 -> START, else WAIT_AVG.
//  WAIT_AVG: avg_new -> latch avg_speed into spd[path_sel], STORE. Timeout TMO -> FAULT.
//  FAULT: set fault bit for path_sel, spd[path_sel]=0, 1-cycle clr pulse on avg_reset, NEXT.
//  STORE: 1 cycle, NEXT. avg_new outside WAIT_AVG is ignored.
//  NEXT: path_sel<3 -> path_sel+1, clear sample count, SETTLE (enable is not checked here).
//   path_sel==3 -> REPORT.
//  REPORT: speed_ns/speed_ew = sign-extended 17-bit differences; path_fault <= accumulator;
//   frame_valid=1 for 1 cycle. path_sel wraps to 0.
//   Then enable=1 -> SETTLE; enable=0 -> IDLE.
//  enable is sampled only in IDLE and REPORT; a frame in progress always completes.
//  Reset mid-frame: returns to IDLE on the next edge. avg_reset is high during reset, so the
//   averager restarts cleanly. Outputs take their reset values.
//  Arithmetic: 17-bit differences never overflow. Counters: sample count AVG_N+2 bits,
//   timeout and idle counters 12 bits minimum.
// TESTING
//  1. Detector model replies meas_done 10 cycles after meas_start; averager returns spd
//     {100,-100,50,20}. Expect speed_ns=200, speed_ew=30, path_fault=0, one frame_valid,
//     and 4*129 meas_start pulses per frame.
//  2. Detector silent on path 2 only. Expect meas_start count stops at TMO+1 cycles on that path,
//     one avg_reset pulse, path_fault=4'b0100, speed_ew=0-spd[3].
//  3. meas_done coincident with the last timeout cycle. Expect no fault; sample counted.
//  4. enable dropped during path 1. Expect frame completes, frame_valid pulses once,
//     then IDLE with busy=0 and no further meas_start.
//  5. reset asserted during WAIT_AVG of path 3. Expect avg_reset high, next cycle busy=0,
//     path_sel=0, no frame_valid. After release with enable=1, a full frame restarts at path 0.
//  6. Check avg_endata pulses are >= GAP+2 cycles apart, and avg_phase is held
//     equal to the captured meas_phase.

Source files
------------

// File: rtl/wind_meas_scheduler.sv
// wind_meas_scheduler
//   Frame controller for the ultrasonic wind path. Visits the four transducer paths in order
//   (0=N->S, 1=S->N, 2=E->W, 3=W->E). On each path it fires the shared phase detector
//   (1<<AVG_N)+1 times and streams every phase result into the shared averaging unit. It then
//   collects one averaged speed for the path. After path 3 it publishes the per-axis
//   differential speeds and the per-path fault flags.
//
// Ports
//   clock, reset     system clock, synchronous active-high reset
//   enable_i         run frames continuously while high (sampled in idle and at frame end)
//   path_sel_o       transducer path currently driven
//   meas_start_o     1-cycle burst trigger to the phase detector
//   meas_done_i      detector result strobe, meas_phase_i valid in the same cycle
//   avg_endata_o     1-cycle sample strobe to the averaging unit, data on avg_phase_o
//   avg_reset_o      averaging unit reset (system reset or path-fault clear)
//   avg_new_i        averaged speed strobe, value on avg_speed_i
//   speed_ns_o/ew_o  signed spd[0]-spd[1] / spd[2]-spd[3], updated with frame_valid_o
//   path_fault_o     bit p set if path p timed out in the last reported frame
//   busy_o           high whenever the controller is not idle
//
// SETTLE and GAP must be at least 1; all cycle parameters must fit in 16 bits.

module wind_meas_scheduler #(
   parameter int unsigned AVG_N  = 7,
   parameter int unsigned SETTLE = 255,
   parameter int unsigned GAP    = 15,
   parameter int unsigned TMO    = 4095
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable_i,
   output logic [1:0]  path_sel_o,
   output logic        meas_start_o,
   input  logic        meas_done_i,
   input  logic [18:0] meas_phase_i,
   output logic        avg_endata_o,
   output logic [18:0] avg_phase_o,
   output logic        avg_reset_o,
   input  logic        avg_new_i,
   input  logic [15:0] avg_speed_i,
   output logic [16:0] speed_ns_o,
   output logic [16:0] speed_ew_o,
   output logic        frame_valid_o,
   output logic [3:0]  path_fault_o,
   output logic        busy_o
);

   localparam int unsigned     SmpW       = AVG_N + 2;
   localparam logic [SmpW-1:0] NSamp      = SmpW'((1 << AVG_N) + 1);
   localparam int unsigned     CntW       = 16;
   localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE - 1);
   localparam logic [CntW-1:0] GapLast    = CntW'(GAP - 1);
   localparam logic [CntW-1:0] TmoLast    = CntW'(TMO);

   typedef enum logic [3:0] {
      StIdle, StSettle, StStart, StWaitMeas, StFeed, StGap,
      StWaitAvg, StStore, StFault, StNext, StReport
   } state_e;

   state_e           state_q;
   logic [1:0]       path_sel_q;
   logic             meas_start_q;
   logic             avg_endata_q;
   logic [18:0]      avg_phase_q;
   logic             clr_q;
   logic [16:0]      speed_ns_q;
   logic [16:0]      speed_ew_q;
   logic             frame_valid_q;
   logic [3:0]       path_fault_q;
   logic [3:0]       fault_acc_q;
   logic [15:0]      spd_q [4];
   logic [CntW-1:0]  cnt_q;   // settle / gap idle counter
   logic [CntW-1:0]  tmo_q;   // wait timeout counter
   logic [SmpW-1:0]  smp_q;   // strobes issued on the current path

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StIdle;
         path_sel_q    <= 2'd0;
         meas_start_q  <= 1'b0;
         avg_endata_q  <= 1'b0;
         avg_phase_q   <= '0;
         clr_q         <= 1'b0;
         speed_ns_q    <= '0;
         speed_ew_q    <= '0;
         frame_valid_q <= 1'b0;
         path_fault_q  <= '0;
         fault_acc_q   <= '0;
         cnt_q         <= '0;
         tmo_q         <= '0;
         smp_q         <= '0;
         for (int p = 0; p < 4; p++) begin
            spd_q[p] <= '0;
         end
      end else begin
         // Pulse outputs are set on the transition into their state and drop one cycle later.
         meas_start_q  <= 1'b0;
         avg_endata_q  <= 1'b0;
         clr_q         <= 1'b0;
         frame_valid_q <= 1'b0;

         case (state_q)
            StIdle: begin
               if (enable_i) begin
                  path_sel_q  <= 2'd0;
                  fault_acc_q <= '0;
                  smp_q       <= '0;
                  cnt_q       <= '0;
                  state_q     <= StSettle;
               end
            end
            StSettle: begin
               if (cnt_q == SettleLast) begin
                  cnt_q        <= '0;
                  tmo_q        <= '0;
                  meas_start_q <= 1'b1;
                  state_q      <= StStart;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StStart: begin
               tmo_q   <= '0;
               state_q <= StWaitMeas;
            end
            StWaitMeas: begin
               // A result arriving in the expiry cycle still counts.
               if (meas_done_i) begin
                  avg_phase_q  <= meas_phase_i;
                  avg_endata_q <= 1'b1;
                  state_q      <= StFeed;
               end else if (tmo_q == TmoLast) begin
                  clr_q   <= 1'b1;
                  state_q <= StFault;
               end else begin
                  tmo_q <= tmo_q + CntW'(1);
               end
            end
            StFeed: begin
               smp_q   <= smp_q + SmpW'(1);
               cnt_q   <= '0;
               state_q <= StGap;
            end
            StGap: begin
               if (cnt_q == GapLast) begin
                  cnt_q <= '0;
                  tmo_q <= '0;
                  if (smp_q < NSamp) begin
                     meas_start_q <= 1'b1;
                     state_q      <= StStart;
                  end else begin
                     state_q <= StWaitAvg;
                  end
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
            StWaitAvg: begin
               if (avg_new_i) begin
                  spd_q[path_sel_q] <= avg_speed_i;
                  state_q           <= StStore;
               end else if (tmo_q == TmoLast) begin
                  clr_q   <= 1'b1;
                  state_q <= StFault;
               end else begin
                  tmo_q <= tmo_q + CntW'(1);
               end
            end
            StFault: begin
               fault_acc_q[path_sel_q] <= 1'b1;
               spd_q[path_sel_q]       <= '0;
               state_q                 <= StNext;
            end
            StStore: begin
               state_q <= StNext;
            end
            StNext: begin
               if (path_sel_q != 2'd3) begin
                  path_sel_q <= path_sel_q + 2'd1;
                  smp_q      <= '0;
                  cnt_q      <= '0;
                  state_q    <= StSettle;
               end else begin
                  // Sign-extend to 17 bits so the difference cannot overflow.
                  speed_ns_q    <= {spd_q[0][15], spd_q[0]} - {spd_q[1][15], spd_q[1]};
                  speed_ew_q    <= {spd_q[2][15], spd_q[2]} - {spd_q[3][15], spd_q[3]};
                  path_fault_q  <= fault_acc_q;
                  frame_valid_q <= 1'b1;
                  path_sel_q    <= 2'd0;
                  state_q       <= StReport;
               end
            end
            StReport: begin
               smp_q       <= '0;
               cnt_q       <= '0;
               fault_acc_q <= '0;
               state_q     <= enable_i ? StSettle : StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign path_sel_o    = path_sel_q;
   assign meas_start_o  = meas_start_q;
   assign avg_endata_o  = avg_endata_q;
   assign avg_phase_o   = avg_phase_q;
   assign avg_reset_o   = reset | clr_q;
   assign speed_ns_o    = speed_ns_q;
   assign speed_ew_o    = speed_ew_q;
   assign frame_valid_o = frame_valid_q;
   assign path_fault_o  = path_fault_q;
   assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_wind_meas_scheduler.sv
// Testbench for wind_meas_scheduler with shortened timing parameters. Detector and averager
// are behavioural models; expected phases and frame results go into queues as they are
// driven and are compared when the DUT produces them.

module tb_wind_meas_scheduler;
   localparam int AVG_N   = 2;
   localparam int SETTLE  = 20;
   localparam int GAP     = 4;
   localparam int TMO     = 40;
   localparam int NSAMP   = (1 << AVG_N) + 1;
   localparam int DLY     = 10;
   localparam int AVG_LAT = GAP + 3;   // lands inside the averaging wait window
   localparam int BUDGET  = 5000;

   logic               clock = 1'b0;
   logic               reset;
   logic               enable;
   logic [1:0]         path_sel;
   logic               meas_start;
   logic               meas_done;
   logic signed [18:0] meas_phase;
   logic               avg_endata;
   logic signed [18:0] avg_phase;
   logic               avg_reset;
   logic               avg_new;
   logic signed [15:0] avg_speed;
   logic signed [16:0] speed_ns;
   logic signed [16:0] speed_ew;
   logic               frame_valid;
   logic [3:0]         path_fault;
   logic               busy;

   always #5 clock = ~clock;

   wind_meas_scheduler #(
      .AVG_N  (AVG_N),
      .SETTLE (SETTLE),
      .GAP    (GAP),
      .TMO    (TMO)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .enable_i      (enable),
      .path_sel_o    (path_sel),
      .meas_start_o  (meas_start),
      .meas_done_i   (meas_done),
      .meas_phase_i  (meas_phase),
      .avg_endata_o  (avg_endata),
      .avg_phase_o   (avg_phase),
      .avg_reset_o   (avg_reset),
      .avg_new_i     (avg_new),
      .avg_speed_i   (avg_speed),
      .speed_ns_o    (speed_ns),
      .speed_ew_o    (speed_ew),
      .frame_valid_o (frame_valid),
      .path_fault_o  (path_fault),
      .busy_o        (busy)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   typedef struct {
      int ns;
      int ew;
      int fault;
      int starts;
      int clrs;
   } frame_t;

   frame_t exp_q[$];
   int     ph_q[$];

   int spd_tbl[4];
   int dly_tbl[4];
   bit silent[4];

   task automatic expect_frame(input int ns, input int ew, input int fault, input int starts,
                               input int clrs);
      frame_t f;
      f.ns     = ns;
      f.ew     = ew;
      f.fault  = fault;
      f.starts = starts;
      f.clrs   = clrs;
      exp_q.push_back(f);
   endtask

   // Phase detector: replies dly_tbl[path] cycles after meas_start unless the path is silent.
   int det_cd = 0;
   always @(negedge clock) begin
      meas_done  = 1'b0;
      meas_phase = 19'($urandom);
      if (reset) begin
         det_cd = 0;
      end else begin
         if (det_cd > 0) begin
            det_cd--;
            if (det_cd == 0) begin
               meas_done = 1'b1;
               ph_q.push_back(int'(meas_phase));
            end
         end
         if (meas_start && !silent[path_sel]) det_cd = dly_tbl[path_sel];
      end
   end

   // Averager: after NSAMP strobes returns spd_tbl[path]; also emits a stray avg_new with
   // junk data after the first strobe, which the controller must ignore.
   int avg_cnt = 0;
   int avg_cd  = 0;
   int sp_cd   = 0;
   always @(negedge clock) begin
      avg_new   = 1'b0;
      avg_speed = 16'($urandom);
      if (avg_reset) begin
         avg_cnt = 0;
         avg_cd  = 0;
         sp_cd   = 0;
      end else begin
         if (avg_cd > 0) begin
            avg_cd--;
            if (avg_cd == 0) begin
               avg_new   = 1'b1;
               avg_speed = 16'(spd_tbl[path_sel]);
            end
         end
         if (sp_cd > 0) begin
            sp_cd--;
            if (sp_cd == 0) begin
               avg_new   = 1'b1;
               avg_speed = 16'sh7abc;
            end
         end
         if (avg_endata) begin
            avg_cnt++;
            if (avg_cnt == 1) sp_cd = 2;
            if (avg_cnt == NSAMP) begin
               avg_cnt = 0;
               avg_cd  = AVG_LAT;
            end
         end
      end
   end

   // Monitor / scoreboard.
   int     cyc = 0;
   int     start_cnt = 0;
   int     clr_cnt = 0;
   int     total_starts = 0;
   int     last_start = 0;
   int     last_strobe = 0;
   int     last_phase = 0;
   bit     have_strobe = 1'b0;
   frame_t got;
   always @(negedge clock) begin
      cyc++;
      if (reset) begin
         start_cnt   = 0;
         clr_cnt     = 0;
         have_strobe = 1'b0;
         ph_q.delete();
      end else begin
         if (meas_start) begin
            start_cnt++;
            total_starts++;
            last_start = cyc;
         end
         if (avg_reset) begin
            clr_cnt++;
            check_eq("clr_after_start", cyc - last_start, TMO + 2);
         end
         if (avg_endata) begin
            if (ph_q.size() == 0) check_eq("phase_unexpected", ph_q.size(), 1);
            else check_eq("avg_phase", int'(avg_phase), ph_q.pop_front());
            if (have_strobe) check_eq("strobe_spacing", int'((cyc - last_strobe) >= GAP + 2), 1);
            have_strobe = 1'b1;
            last_strobe = cyc;
            last_phase  = int'(avg_phase);
         end else if (have_strobe && cyc == last_strobe + 1) begin
            check_eq("avg_phase_hold", int'(avg_phase), last_phase);
         end
         if (frame_valid) begin
            if (exp_q.size() == 0) begin
               check_eq("frame_unexpected", exp_q.size(), 1);
            end else begin
               got = exp_q.pop_front();
               check_eq("speed_ns", int'(speed_ns), got.ns);
               check_eq("speed_ew", int'(speed_ew), got.ew);
               check_eq("path_fault", int'(path_fault), got.fault);
               check_eq("meas_starts", start_cnt, got.starts);
               check_eq("clr_pulses", clr_cnt, got.clrs);
            end
            start_cnt = 0;
            clr_cnt   = 0;
         end
      end
   end

   task automatic wait_frame();
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!frame_valid && n < BUDGET);
      if (!frame_valid) check_eq("frame_timeout", int'(frame_valid), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int strobes;
      int snap;
      reset  = 1'b1;
      enable = 1'b0;
      for (int p = 0; p < 4; p++) begin
         dly_tbl[p] = DLY;
         silent[p]  = 1'b0;
      end
      spd_tbl[0] = 100; spd_tbl[1] = -100; spd_tbl[2] = 50; spd_tbl[3] = 20;

      // Reset state.
      repeat (3) @(negedge clock);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_path_sel", int'(path_sel), 0);
      check_eq("rst_avg_reset", int'(avg_reset), 1);
      check_eq("rst_meas_start", int'(meas_start), 0);
      check_eq("rst_avg_endata", int'(avg_endata), 0);
      check_eq("rst_frame_valid", int'(frame_valid), 0);
      check_eq("rst_avg_phase", int'(avg_phase), 0);
      check_eq("rst_speed_ns", int'(speed_ns), 0);
      check_eq("rst_speed_ew", int'(speed_ew), 0);
      check_eq("rst_path_fault", int'(path_fault), 0);
      #1 reset = 1'b0;
      repeat (5) @(negedge clock);
      check_eq("idle_busy", int'(busy), 0);
      check_eq("idle_avg_reset", int'(avg_reset), 0);
      check_eq("idle_starts", total_starts, 0);

      // 1: clean frame.
      expect_frame(200, 30, 0, 4 * NSAMP, 0);
      enable = 1'b1;
      wait_frame();

      // 2: detector silent on path 2.
      silent[2] = 1'b1;
      expect_frame(200, 0 - spd_tbl[3], 4'b0100, 3 * NSAMP + 1, 1);
      wait_frame();

      // 3: path 1 results arrive in the last timeout cycle.
      silent[2]  = 1'b0;
      dly_tbl[1] = TMO + 1;
      spd_tbl[0] = -300; spd_tbl[1] = 250; spd_tbl[2] = -7; spd_tbl[3] = 1000;
      expect_frame(-550, -1007, 0, 4 * NSAMP, 0);
      wait_frame();

      // 4: enable dropped during path 1; frame completes, then idle.
      dly_tbl[1] = DLY;
      spd_tbl[0] = 5; spd_tbl[1] = 6; spd_tbl[2] = 7; spd_tbl[3] = 8;
      expect_frame(-1, -1, 0, 4 * NSAMP, 0);
      n = 0;
      while (path_sel != 2'd1 && n < BUDGET) begin
         @(negedge clock);
         n++;
      end
      check_eq("reach_path1", int'(path_sel), 1);
      enable = 1'b0;
      wait_frame();
      @(negedge clock);
      check_eq("stop_busy", int'(busy), 0);
      check_eq("stop_path_sel", int'(path_sel), 0);
      snap = total_starts;
      repeat (3 * SETTLE) @(negedge clock);
      check_eq("stop_no_starts", total_starts - snap, 0);
      check_eq("stop_still_idle", int'(busy), 0);

      // 5: reset during the averaging wait on path 3.
      spd_tbl[0] = 100; spd_tbl[1] = -100; spd_tbl[2] = 50; spd_tbl[3] = 20;
      enable  = 1'b1;
      n       = 0;
      strobes = 0;
      while (strobes < NSAMP && n < 4 * BUDGET) begin
         @(negedge clock);
         n++;
         if (path_sel == 2'd3 && avg_endata) strobes++;
      end
      check_eq("reach_path3_last", strobes, NSAMP);
      repeat (GAP + 1) @(negedge clock);
      #1 reset = 1'b1;
      #1 check_eq("midrst_avg_reset", int'(avg_reset), 1);
      @(negedge clock);
      check_eq("midrst_busy", int'(busy), 0);
      check_eq("midrst_path_sel", int'(path_sel), 0);
      check_eq("midrst_frame_valid", int'(frame_valid), 0);
      check_eq("midrst_speed_ns", int'(speed_ns), 0);
      check_eq("midrst_speed_ew", int'(speed_ew), 0);
      check_eq("midrst_path_fault", int'(path_fault), 0);
      @(negedge clock);
      #1 reset = 1'b0;
      expect_frame(200, 30, 0, 4 * NSAMP, 0);
      repeat (2) @(negedge clock);
      check_eq("restart_busy", int'(busy), 1);
      check_eq("restart_path_sel", int'(path_sel), 0);
      enable = 1'b0;
      wait_frame();
      repeat (3) @(negedge clock);
      check_eq("final_idle", int'(busy), 0);
      check_eq("pending_frames", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
